alu_seq: RTL and testbench

- Parametrised, registered arithmetic/logic unit. Successor to the fixed 4-bit registered adder.
- Adds selectable operations, status flags, a start/done handshake and a multi-cycle unsigned shift-add multiplier.
- Sits between the operand registers and the result/display path. Operands are captured on start and the result is held stable until the next completion.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: operands and op in, result, flags and handshake out.
interface alu_seq_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     reg0;
  logic [WIDTH-1:0]     reg1;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   ans;
  logic                 carry;
  logic                 zero;
  logic                 overflow;
  logic                 err;

  modport master (
    output start, op, reg0, reg1,
    input  busy, done, ans, carry, zero, overflow, err
  );

  modport slave (
    input  start, op, reg0, reg1,
    output busy, done, ans, carry, zero, overflow, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ADD/SUB/logic ops, WIDTH-cycle shift-add MUL.
// Starts are accepted only in IDLE; results and flags hold until the next done pulse.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nx;
  logic [RW-1:0]    acc, acc_nx;
  logic [RW-1:0]    mcand, mcand_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [RW-1:0]    ans, ans_nx;
  logic             carry, carry_nx;
  logic             zero, zero_nx;
  logic             overflow, overflow_nx;
  logic             err, err_nx;
  logic             busy, busy_nx;
  logic             done, done_nx;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [RW-1:0]    acc_add;

  always_comb begin
    sum     = {1'b0, bus.reg0} + {1'b0, bus.reg1};
    diff    = {1'b0, bus.reg0} + {1'b0, ~bus.reg1} + (WIDTH+1)'(1);
    acc_add = mplier[0] ? (acc + mcand) : acc;
  end

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    mcand_nx    = mcand;
    mplier_nx   = mplier;
    cnt_nx      = cnt;
    ans_nx      = ans;
    carry_nx    = carry;
    zero_nx     = zero;
    overflow_nx = overflow;
    err_nx      = err;
    busy_nx     = busy;
    done_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          carry_nx    = 1'b0;
          overflow_nx = 1'b0;
          err_nx      = 1'b0;
          done_nx     = 1'b1;
          case (bus.op)
            OP_ADD: begin
              ans_nx      = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              carry_nx    = sum[WIDTH];
              overflow_nx = (bus.reg0[WIDTH-1] == bus.reg1[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.reg0[WIDTH-1]);
            end
            OP_SUB: begin
              ans_nx      = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              carry_nx    = diff[WIDTH];
              overflow_nx = (bus.reg0[WIDTH-1] != bus.reg1[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.reg0[WIDTH-1]);
            end
            OP_AND: ans_nx = {{WIDTH{1'b0}}, bus.reg0 & bus.reg1};
            OP_OR:  ans_nx = {{WIDTH{1'b0}}, bus.reg0 | bus.reg1};
            OP_XOR: ans_nx = {{WIDTH{1'b0}}, bus.reg0 ^ bus.reg1};
            OP_MUL: begin
              // Flags and result stay untouched until the product lands.
              carry_nx    = carry;
              overflow_nx = overflow;
              err_nx      = err;
              done_nx     = 1'b0;
              state_nx    = MUL;
              busy_nx     = 1'b1;
              acc_nx      = '0;
              cnt_nx      = '0;
              mcand_nx    = {{WIDTH{1'b0}}, bus.reg0};
              mplier_nx   = bus.reg1;
            end
            default: begin
              ans_nx = '0;
              err_nx = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_nx    = acc_add;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx    = IDLE;
          busy_nx     = 1'b0;
          done_nx     = 1'b1;
          ans_nx      = acc_add;
          carry_nx    = 1'b0;
          overflow_nx = |acc_add[RW-1:WIDTH];
          err_nx      = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (done_nx) zero_nx = (ans_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      ans      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      mcand    <= mcand_nx;
      mplier   <= mplier_nx;
      cnt      <= cnt_nx;
      ans      <= ans_nx;
      carry    <= carry_nx;
      zero     <= zero_nx;
      overflow <= overflow_nx;
      err      <= err_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  assign bus.ans      = ans;
  assign bus.carry    = carry;
  assign bus.zero     = zero;
  assign bus.overflow = overflow;
  assign bus.err      = err;
  assign bus.busy     = busy;
  assign bus.done     = done;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4 and WIDTH=8 with directed, hand-computed vectors.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ans;
    logic        c;
    logic        z;
    logic        v;
    logic        e;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   tests = 0;
  int   fails = 0;

  alu_seq_if #(.WIDTH(4)) b4();
  alu_seq_if #(.WIDTH(8)) b8();

  alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  function automatic exp_t mk(input logic [15:0] a, input logic c, input logic z,
                              input logic v, input logic e);
    mk = {a, c, z, v, e};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (b4.done) begin
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done4: got done=1 with ans=%h, expected no done", b4.ans);
      end else
        chk("result4", {8'h00, b4.ans, b4.carry, b4.zero, b4.overflow, b4.err}, q4.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b8.done) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done8: got done=1 with ans=%h, expected no done", b8.ans);
      end else
        chk("result8", {b8.ans, b8.carry, b8.zero, b8.overflow, b8.err}, q8.pop_front());
    end
  end

  task automatic go4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    b4.start = 1'b1; b4.op = op; b4.reg0 = a; b4.reg1 = b;
  endtask

  task automatic go8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    b8.start = 1'b1; b8.op = op; b8.reg0 = a; b8.reg1 = b;
  endtask

  task automatic idle4;
    @(negedge clk);
    b4.start = 1'b0;
  endtask

  task automatic idle8;
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  // Called right after go4 of a MUL; optionally fires an ADD start while busy.
  task automatic mul_wait4(input bit inject);
    int k = 0;
    int nb = 0;
    @(posedge clk); #1;
    b4.start = 1'b0;
    chk("busy_at_accept4", b4.busy, 1);
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (b4.busy) nb++;
      if (inject && k == 1) begin
        b4.start = 1'b1; b4.op = 3'b000; b4.reg0 = 4'h1; b4.reg1 = 4'h1;
      end
      if (inject && k == 2) b4.start = 1'b0;
      if (b4.done) break;
    end
    chk("mul_latency4", k, 4);
    chk("mul_busy_cycles4", nb, 3);
  endtask

  task automatic mul_wait8;
    int k = 0;
    @(posedge clk); #1;
    b8.start = 1'b0;
    while (k < 60) begin
      @(posedge clk); #1;
      k++;
      if (b8.done) break;
    end
    chk("mul_latency8", k, 8);
  endtask

  initial begin
    rst_n = 1'b0;
    b4.start = 1'b0; b4.op = 3'b000; b4.reg0 = '0; b4.reg1 = '0;
    b8.start = 1'b0; b8.op = 3'b000; b8.reg0 = '0; b8.reg1 = '0;
    repeat (3) @(negedge clk);
    chk("reset4", {b4.busy, b4.done, b4.ans, b4.carry, b4.zero, b4.overflow, b4.err}, 0);
    chk("reset8", {b8.busy, b8.done, b8.ans, b8.carry, b8.zero, b8.overflow, b8.err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    go4(3'b000, 4'd9, 4'd8);  q4.push_back(mk(16'h0001, 1, 0, 1, 0));
    idle4;
    go4(3'b001, 4'd3, 4'd5);  q4.push_back(mk(16'h000E, 0, 0, 0, 0));
    go4(3'b001, 4'd5, 4'd5);  q4.push_back(mk(16'h0000, 1, 1, 0, 0));
    idle4;

    go4(3'b101, 4'd15, 4'd15); q4.push_back(mk(16'h00E1, 0, 0, 1, 0));
    mul_wait4(1'b1);
    repeat (3) @(negedge clk);
    chk("mul_hold4", b4.ans, 8'hE1);

    go4(3'b100, 4'hA, 4'hA);  q4.push_back(mk(16'h0000, 0, 1, 0, 0));
    go4(3'b111, 4'h3, 4'h4);  q4.push_back(mk(16'h0000, 0, 1, 0, 1));
    go4(3'b010, 4'hC, 4'h6);  q4.push_back(mk(16'h0004, 0, 0, 0, 0));
    idle4;

    // MUL aborted by asynchronous reset two cycles in.
    go4(3'b101, 4'd3, 4'd5);
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset4", {b4.busy, b4.done, b4.ans, b4.carry, b4.zero, b4.overflow, b4.err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    go4(3'b101, 4'd3, 4'd5);  q4.push_back(mk(16'h000F, 0, 0, 0, 0));
    mul_wait4(1'b0);

    go8(3'b101, 8'd200, 8'd100); q8.push_back(mk(16'h4E20, 0, 0, 1, 0));
    mul_wait8;
    go8(3'b000, 8'd127, 8'd1);   q8.push_back(mk(16'h0080, 0, 0, 1, 0));
    idle8;

    repeat (4) @(negedge clk);
    chk("drained4", q4.size(), 0);
    chk("drained8", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
